// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: byte/half/word load/store on a word array plus MEM/WB register
// Faulting, frozen or reset-cycle accesses never touch the array.
module mem_stage #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic [31:0] alu_res,
   input  logic [31:0] st_val,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [1:0]  mem_size,
   input  logic        ld_signed,
   input  logic        wb_en_in,
   input  logic [4:0]  dest_in,
   output logic        wb_en,
   output logic [4:0]  dest,
   output logic        mem_r_en_out,
   output logic [31:0] alu_res_out,
   output logic [31:0] mem_res,
   output logic        mem_fault
);

   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] off;
   logic [1:0]  lane;
   logic [AW-1:0] widx;
   logic        in_range;
   logic        misalign;
   logic        fault;
   logic        we;
   logic [31:0] rword;
   logic [31:0] ld_data;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // A base above alu_res wraps to a huge offset, so one range check covers both ends.
   assign off      = alu_res - ADDR_BASE;
   assign lane     = off[1:0];
   assign widx     = off[AW+1:2];
   assign in_range = {2'b00, off[31:2]} < DEPTH_U;
   assign rword    = in_range ? mem[widx] : 32'd0;

   always_comb begin
      misalign = 1'b0;
      wdata    = st_val;
      be       = 4'b1111;
      byte_v   = 8'd0;
      half_v   = 16'd0;
      ld_data  = rword;
      case (mem_size)
         2'd0: begin
            wdata = {4{st_val[7:0]}};
            be    = 4'b0001 << lane;
            case (lane)
               2'd0:    byte_v = rword[7:0];
               2'd1:    byte_v = rword[15:8];
               2'd2:    byte_v = rword[23:16];
               default: byte_v = rword[31:24];
            endcase
            ld_data = {{24{ld_signed & byte_v[7]}}, byte_v};
         end
         2'd1: begin
            misalign = off[0];
            wdata    = {2{st_val[15:0]}};
            be       = lane[1] ? 4'b1100 : 4'b0011;
            half_v   = lane[1] ? rword[31:16] : rword[15:0];
            ld_data  = {{16{ld_signed & half_v[15]}}, half_v};
         end
         default: misalign = |lane;
      endcase
   end

   assign fault = (mem_r_en | mem_w_en) & (~in_range | misalign);
   assign we    = mem_w_en & ~fault & ~freeze & ~rst;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en        <= 1'b0;
         dest         <= 5'd0;
         mem_r_en_out <= 1'b0;
         alu_res_out  <= 32'd0;
         mem_res      <= 32'd0;
         mem_fault    <= 1'b0;
      end else if (!freeze) begin
         wb_en        <= wb_en_in & ~fault;
         dest         <= dest_in;
         mem_r_en_out <= mem_r_en;
         alu_res_out  <= alu_res;
         mem_res      <= (mem_r_en & ~fault) ? ld_data : 32'd0;
         mem_fault    <= fault;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed bench for mem_stage with a byte-addressed reference model
module tb_mem_stage;

   localparam int          DEPTH = 256;
   localparam logic [31:0] BASE  = 32'd1024;

   logic        clk = 1'b0;
   logic        rst, freeze, mem_r_en, mem_w_en, ld_signed, wb_en_in;
   logic [31:0] alu_res, st_val;
   logic [1:0]  mem_size;
   logic [4:0]  dest_in;
   logic        wb_en, mem_r_en_out, mem_fault;
   logic [4:0]  dest;
   logic [31:0] alu_res_out, mem_res;

   int checks = 0;
   int errors = 0;

   mem_stage #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .alu_res(alu_res), .st_val(st_val),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_size(mem_size), .ld_signed(ld_signed),
      .wb_en_in(wb_en_in), .dest_in(dest_in), .wb_en(wb_en), .dest(dest),
      .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out), .mem_res(mem_res),
      .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: memory as bytes with a written flag; outputs derived from the rules directly.
   logic [7:0]  bmem   [4*DEPTH];
   bit          bknown [4*DEPTH];
   logic        e_valid = 1'b0, e_known = 1'b0;
   logic        e_wb, e_rd, e_flt;
   logic [4:0]  e_dest;
   logic [31:0] e_alu, e_res;

   initial for (int i = 0; i < 4*DEPTH; i++) bknown[i] = 1'b0;

   always @(posedge clk) begin
      logic [31:0] o, v, n;
      logic        f, kn;
      if (rst) begin
         e_valid <= 1'b1; e_known <= 1'b1;
         e_wb <= 1'b0; e_dest <= 5'd0; e_rd <= 1'b0; e_alu <= 32'd0; e_res <= 32'd0; e_flt <= 1'b0;
      end else if (!freeze) begin
         o  = alu_res - BASE;
         n  = (mem_size == 2'd0) ? 32'd1 : (mem_size == 2'd1) ? 32'd2 : 32'd4;
         f  = (mem_r_en || mem_w_en) && (o >= 4*DEPTH || (o % n) != 0);
         v  = 32'd0;
         kn = 1'b1;
         if (mem_r_en && !f) begin
            for (int i = 0; i < int'(n); i++) begin
               if (bknown[o + i]) v = v | (32'(bmem[o + i]) << (8*i));
               else kn = 1'b0;
            end
            if (ld_signed && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         end
         if (mem_w_en && !f) begin
            for (int i = 0; i < int'(n); i++) begin
               bmem[o + i]   <= 8'(st_val >> (8*i));
               bknown[o + i] <= 1'b1;
            end
         end
         e_wb <= wb_en_in && !f; e_dest <= dest_in; e_rd <= mem_r_en; e_alu <= alu_res;
         e_res <= v; e_known <= kn; e_flt <= f;
      end
   end

   always @(negedge clk) begin
      if (e_valid) begin
         chk("m_wb_en", 32'(wb_en), 32'(e_wb));
         chk("m_dest", 32'(dest), 32'(e_dest));
         chk("m_mem_r_en_out", 32'(mem_r_en_out), 32'(e_rd));
         chk("m_alu_res_out", alu_res_out, e_alu);
         chk("m_mem_fault", 32'(mem_fault), 32'(e_flt));
         if (e_known) chk("m_mem_res", mem_res, e_res);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic r, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] sv, input logic wbe, input logic [4:0] d);
      mem_r_en = r; mem_w_en = w; mem_size = sz; ld_signed = sg;
      alu_res = a; st_val = sv; wb_en_in = wbe; dest_in = d;
      step();
   endtask

   task automatic fault_chk(input string name);
      chk({name, "_fault"}, 32'(mem_fault), 32'd1);
      chk({name, "_wb"}, 32'(wb_en), 32'd0);
      chk({name, "_res"}, mem_res, 32'd0);
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0;
      mem_r_en = 0; mem_w_en = 0; mem_size = 0; ld_signed = 0;
      alu_res = 0; st_val = 0; wb_en_in = 0; dest_in = 0;
      step(); step();
      rst = 1'b0;

      op(0, 1, 2, 0, 32'd1024, 32'hDEADBEEF, 0, 0);
      // every input nonzero, including freeze, with rst high
      rst = 1'b1; freeze = 1'b1;
      op(1, 1, 2, 1, 32'd1024, 32'h11111111, 1, 31);
      chk("rst_wb", 32'(wb_en), 32'd0);
      chk("rst_dest", 32'(dest), 32'd0);
      chk("rst_rd", 32'(mem_r_en_out), 32'd0);
      chk("rst_alu", alu_res_out, 32'd0);
      chk("rst_res", mem_res, 32'd0);
      chk("rst_fault", 32'(mem_fault), 32'd0);
      rst = 1'b0; freeze = 1'b0;
      op(1, 0, 2, 0, 32'd1024, 0, 1, 2);
      chk("rst_keep_mem", mem_res, 32'hDEADBEEF);

      op(0, 1, 2, 0, 32'd1028, 32'h12345678, 0, 0);
      op(1, 0, 2, 0, 32'd1028, 0, 1, 4);
      chk("rt_res", mem_res, 32'h12345678);
      chk("rt_rd", 32'(mem_r_en_out), 32'd1);
      chk("rt_alu", alu_res_out, 32'd1028);

      op(0, 1, 2, 0, 32'd1032, 32'h0, 0, 0);
      op(0, 1, 0, 0, 32'd1035, 32'hFFFFFF80, 0, 0);
      op(0, 1, 1, 0, 32'd1032, 32'h1234BEEF, 0, 0);
      op(1, 0, 2, 0, 32'd1032, 0, 1, 5);
      chk("lw_lanes", mem_res, 32'h8000BEEF);
      op(1, 0, 0, 1, 32'd1035, 0, 1, 5);
      chk("lb", mem_res, 32'hFFFFFF80);
      op(1, 0, 0, 0, 32'd1035, 0, 1, 5);
      chk("lbu", mem_res, 32'h00000080);
      op(1, 0, 1, 1, 32'd1032, 0, 1, 5);
      chk("lh", mem_res, 32'hFFFFBEEF);
      op(1, 0, 1, 0, 32'd1032, 0, 1, 5);
      chk("lhu", mem_res, 32'h0000BEEF);

      op(0, 1, 2, 0, 32'd1030, 32'h99999999, 1, 6);
      fault_chk("sw_misal");
      op(0, 1, 1, 0, 32'd1033, 32'h99999999, 1, 6);
      fault_chk("sh_odd");
      op(1, 0, 2, 0, 32'd1020, 0, 1, 6);
      fault_chk("lw_below");
      op(1, 0, 2, 0, BASE + 4*DEPTH, 0, 1, 6);
      fault_chk("lw_above");
      op(1, 0, 2, 0, 32'd1028, 0, 1, 6);
      chk("flt_keep0", mem_res, 32'h12345678);
      op(1, 0, 2, 0, 32'd1032, 0, 1, 6);
      chk("flt_keep1", mem_res, 32'h8000BEEF);

      op(0, 1, 2, 0, 32'd1040, 32'h0, 0, 0);
      op(1, 0, 2, 0, 32'd1024, 0, 1, 3);
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op(i[0], 1, 2, 0, 32'd1040, (i == 2) ? 32'hAAAA5555 : 32'h1111_2222 * (i + 1), 1, 5'(10 + i));
         chk("frz_res", mem_res, 32'hDEADBEEF);
         chk("frz_alu", alu_res_out, 32'd1024);
         chk("frz_dest", 32'(dest), 32'd3);
      end
      freeze = 1'b0;
      // load in the same cycle as the store sees pre-store contents
      op(1, 1, 2, 0, 32'd1040, 32'hAAAA5555, 0, 0);
      chk("frz_unchanged", mem_res, 32'h0);
      op(1, 0, 2, 0, 32'd1040, 0, 1, 8);
      chk("frz_commit", mem_res, 32'hAAAA5555);

      op(0, 0, 2, 0, 32'hFFFFFFFF, 32'h5A5A5A5A, 1, 7);
      chk("pt_alu", alu_res_out, 32'hFFFFFFFF);
      chk("pt_wb", 32'(wb_en), 32'd1);
      chk("pt_dest", 32'(dest), 32'd7);
      chk("pt_fault", 32'(mem_fault), 32'd0);
      chk("pt_res", mem_res, 32'd0);

      op(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline. It consumes the EXE-stage ALU result as either an effective address or a pass-through value. It performs byte/half/word loads and stores against an internal word-organised data memory. It registers everything into the MEM/WB pipeline register feeding write-back.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the data memory.
- ADDR_BASE, 1024, byte address that maps to memory word 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall; holds MEM/WB register and suppresses stores.
- alu_res  in  32  ALU result from EXE (effective address when accessing memory).
- st_val  in  32  store data (rt value); low byte/half used for sb/sh.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- mem_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- ld_signed  in  1  1 = sign-extend byte/half loads (lb/lh), 0 = zero-extend (lbu/lhu).
- wb_en_in  in  1  write-back enable from EXE.
- dest_in  in  5  destination register from EXE.
- wb_en  out  1  registered write-back enable.
- dest  out  5  registered destination.
- mem_r_en_out  out  1  registered load flag (selects mem_res in WB mux).
- alu_res_out  out  32  registered alu_res.
- mem_res  out  32  registered, extended load data.
- mem_fault  out  1  registered flag: access was misaligned or out of range.

## Operation
- Offset: off = alu_res - ADDR_BASE (32-bit wrap-around); word index = off[31:2]; lane = off[1:0]. Little-endian: byte lane k = word bits [8k+7:8k], half at lane 2 = bits [31:16].
- Fault when mem_r_en or mem_w_en is set and any of the following holds:
  - index >= DEPTH_WORDS, which includes alu_res < ADDR_BASE (wrapped).
  - Half access with off[0] = 1.
  - Word access with off[1:0] != 0.
- Store: when mem_w_en & ~fault & ~freeze & ~rst, write only the addressed lanes on the clock edge; other lanes unchanged. A faulting store writes nothing.
- Load: memory read is combinational from the array. Select lane(s), then sign- or zero-extend per ld_signed; word ignores ld_signed. A faulting load, or mem_r_en = 0, yields mem_res = 0.
- mem_r_en and mem_w_en both set: the store is performed, and mem_res captures pre-store contents.
- MEM/WB register: when ~freeze, capture wb_en_in, dest_in, mem_r_en, alu_res, the load data and the fault. On fault, wb_en is forced to 0.
- Freeze: all outputs hold their values and no memory write occurs.
- Reset: wb_en, dest, mem_r_en_out, alu_res_out, mem_res and mem_fault all go to 0 at the first rising edge with rst = 1. rst has priority over freeze. Memory contents are not cleared by rst and are undefined until written.
- The block has no internal state beyond the memory array and the MEM/WB register. It has no handshake; the pipeline advances every unfrozen cycle.

## Timing
- Latency of 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Store-to-load forwarding is through the array. A load in cycle N+1 observes a store committed at edge N. A load in the same cycle as a store to the same word sees old data.
- mem_fault is asserted for exactly the cycle(s) the faulting instruction occupies MEM/WB; it holds under freeze.
- rst asserted mid-stream discards the in-flight instruction. A store presented in the reset cycle is not performed.

## Test plan
- Reset: drive all inputs to nonzero and rst = 1 for one edge. Required: every output = 0. Write word 0xDEADBEEF at 1024 before reset; a later lw at 1024 still returns 0xDEADBEEF.
- Word round-trip: sw 0x12345678 at 1028, then lw at 1028 in the next cycle. Required: mem_res = 0x12345678, mem_r_en_out = 1, alu_res_out = 1028, one cycle after the load.
- Byte lanes: sw 0x00000000 at 1032, sb 0x80 at 1035, sh 0xBEEF at 1032. Required loads:
  - lw gives 0x8000BEEF.
  - lb at 1035 gives 0xFFFFFF80; lbu at 1035 gives 0x00000080.
  - lh at 1032 gives 0xFFFFBEEF; lhu gives 0x0000BEEF.
- Faults: sw at 1030 (misaligned), sh at 1033 (odd), lw at 1020 (below base), lw at 1024 + 4*DEPTH_WORDS. Required: mem_fault = 1, wb_en = 0, mem_res = 0, no memory word modified.
- Freeze: assert freeze for 3 cycles during a sw 0xAAAA5555 at 1040 with changing inputs. Required: outputs held at the prior values and word at 1040 unchanged. After release, the store commits and a following lw returns 0xAAAA5555.
- Pass-through: addi-style instruction with mem_r_en = mem_w_en = 0, alu_res = 0xFFFFFFFF, wb_en_in = 1, dest_in = 7. Required: alu_res_out = 0xFFFFFFFF, wb_en = 1, dest = 7, mem_fault = 0, mem_res = 0.
